data_register_file_mp: RTL and testbench

//  Parametrised successor to the single-port data register file.

---
 rtl/data_register_file_mp_if.sv | 42 ++++
 rtl/data_register_file_mp.sv | 98 +++++++++
 tb/tb_data_register_file_mp.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_register_file_mp_if.sv
// data_register_file_mp_if
//   Groups the register file's decode/writeback bus into one bundle.
//   The master modport is the datapath side that drives addresses, write data,
//   issue claims and clear requests. The slave modport is the register file.
//   Signals:
//     write_enable, write_address, write_data  writeback port
//     read_address_1/2, read_data_1/2          two combinational read ports
//     busy_1/2                                 busy bits of the read addresses
//     issue_enable, issue_address              claim a register for a pending producer
//     clear_request, clear_active              zeroing sweep request and status
interface data_register_file_mp_if #(
  parameter int ADDR_WIDTH_RF = 4,
  parameter int DATA_WIDTH    = 16
);
  logic                     write_enable;
  logic [ADDR_WIDTH_RF-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [ADDR_WIDTH_RF-1:0] read_address_1;
  logic [ADDR_WIDTH_RF-1:0] read_address_2;
  logic [DATA_WIDTH-1:0]    read_data_1;
  logic [DATA_WIDTH-1:0]    read_data_2;
  logic                     busy_1;
  logic                     busy_2;
  logic                     issue_enable;
  logic [ADDR_WIDTH_RF-1:0] issue_address;
  logic                     clear_request;
  logic                     clear_active;

  modport master (
    output write_enable, write_address, write_data,
    output read_address_1, read_address_2,
    output issue_enable, issue_address, clear_request,
    input  read_data_1, read_data_2, busy_1, busy_2, clear_active
  );

  modport slave (
    input  write_enable, write_address, write_data,
    input  read_address_1, read_address_2,
    input  issue_enable, issue_address, clear_request,
    output read_data_1, read_data_2, busy_1, busy_2, clear_active
  );
endinterface

// File: rtl/data_register_file_mp.sv
// data_register_file_mp
//   Register file with one write port, two combinational read ports, optional
//   same-cycle write-to-read forwarding, a per-register busy scoreboard and a
//   sequential clear sweep that zeroes one entry per clock.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      data_register_file_mp_if slave modport (read/write/issue/clear)
//   Parameters:
//     ADDR_WIDTH_RF  register address width, depth = 2**ADDR_WIDTH_RF
//     DATA_WIDTH     register width
//     BYPASS         1 forwards same-cycle write data to matching reads
module data_register_file_mp #(
  parameter int ADDR_WIDTH_RF = 4,
  parameter int DATA_WIDTH    = 16,
  parameter bit BYPASS        = 1'b1
) (
  input logic clk,
  input logic reset_n,
  data_register_file_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH_RF;
  localparam logic [ADDR_WIDTH_RF-1:0] LAST_ADDR = {ADDR_WIDTH_RF{1'b1}};
  localparam logic [ADDR_WIDTH_RF-1:0] ADDR_ONE  = ADDR_WIDTH_RF'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                   r_state;
  logic [ADDR_WIDTH_RF-1:0] r_sweep_count;
  logic                     r_clear_active;
  logic [DATA_WIDTH-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0]         r_busy;

  logic w_bypass_1;
  logic w_bypass_2;

  // Forwarding only while idle; reset_n gates it so reads are zero during reset.
  assign w_bypass_1 = BYPASS && reset_n && (r_state == ST_IDLE) && bus.write_enable &&
                      (bus.write_address == bus.read_address_1);
  assign w_bypass_2 = BYPASS && reset_n && (r_state == ST_IDLE) && bus.write_enable &&
                      (bus.write_address == bus.read_address_2);

  assign bus.read_data_1  = w_bypass_1 ? bus.write_data : r_regs[bus.read_address_1];
  assign bus.read_data_2  = w_bypass_2 ? bus.write_data : r_regs[bus.read_address_2];
  assign bus.busy_1       = r_busy[bus.read_address_1];
  assign bus.busy_2       = r_busy[bus.read_address_2];
  assign bus.clear_active = r_clear_active;

  // Storage, scoreboard and sweep FSM share one block. In IDLE the issue update
  // is placed after the write update so that a same-address issue leaves the
  // register busy. A clear request still lets the same-cycle write/issue land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy         <= '0;
      r_state        <= ST_IDLE;
      r_sweep_count  <= '0;
      r_clear_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.write_enable) begin
            r_regs[bus.write_address] <= bus.write_data;
            r_busy[bus.write_address] <= 1'b0;
          end
          if (bus.issue_enable) begin
            r_busy[bus.issue_address] <= 1'b1;
          end
          if (bus.clear_request) begin
            r_state        <= ST_SWEEP;
            r_sweep_count  <= '0;
            r_clear_active <= 1'b1;
          end
        end
        ST_SWEEP: begin
          r_regs[r_sweep_count] <= '0;
          r_busy[r_sweep_count] <= 1'b0;
          r_sweep_count         <= r_sweep_count + ADDR_ONE;
          if (r_sweep_count == LAST_ADDR) begin
            r_state        <= ST_IDLE;
            r_clear_active <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_clear_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_register_file_mp.sv
// tb_data_register_file_mp
//   Drives two register files from the same stimulus, one with forwarding and
//   one without, and compares both every cycle against a behavioural model of
//   the register array, busy scoreboard and clear sweep. Directed scenarios
//   add literal expectations; a randomized phase follows.
module tb_data_register_file_mp;

  logic clk;
  logic reset_n;
  bit   checkEn;
  int   checks;
  int   failures;

  data_register_file_mp_if #(.ADDR_WIDTH_RF(4), .DATA_WIDTH(16)) busB ();
  data_register_file_mp_if #(.ADDR_WIDTH_RF(4), .DATA_WIDTH(16)) busN ();

  data_register_file_mp #(.ADDR_WIDTH_RF(4), .DATA_WIDTH(16), .BYPASS(1'b1)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busB)
  );

  data_register_file_mp #(.ADDR_WIDTH_RF(4), .DATA_WIDTH(16), .BYPASS(1'b0)) dutN (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busN)
  );

  // The no-forwarding instance sees exactly the same inputs.
  assign busN.write_enable   = busB.write_enable;
  assign busN.write_address  = busB.write_address;
  assign busN.write_data     = busB.write_data;
  assign busN.read_address_1 = busB.read_address_1;
  assign busN.read_address_2 = busB.read_address_2;
  assign busN.issue_enable   = busB.issue_enable;
  assign busN.issue_address  = busB.issue_address;
  assign busN.clear_request  = busB.clear_request;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays plus a "sweeping" flag and the next index to zero.
  logic [15:0] modelMem [16];
  bit          modelBusy [16];
  bit          modelSweeping;
  int          modelSweepIdx;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      modelMem[i]  = 16'h0000;
      modelBusy[i] = 1'b0;
    end
    modelSweeping = 1'b0;
    modelSweepIdx = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modelReset();
    end else if (modelSweeping) begin
      modelMem[modelSweepIdx]  = 16'h0000;
      modelBusy[modelSweepIdx] = 1'b0;
      modelSweepIdx++;
      if (modelSweepIdx == 16) begin
        modelSweeping = 1'b0;
        modelSweepIdx = 0;
      end
    end else begin
      if (busB.write_enable) begin
        modelMem[busB.write_address]  = busB.write_data;
        modelBusy[busB.write_address] = 1'b0;
      end
      if (busB.issue_enable) begin
        modelBusy[busB.issue_address] = 1'b1;
      end
      if (busB.clear_request) begin
        modelSweeping = 1'b1;
        modelSweepIdx = 0;
      end
    end
  end

  function automatic logic [15:0] expRead(input logic [3:0] addr, input bit byp);
    if (!reset_n) return 16'h0000;
    if (byp && !modelSweeping && busB.write_enable && busB.write_address == addr)
      return busB.write_data;
    return modelMem[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("B.read_data_1", 32'(busB.read_data_1), 32'(expRead(busB.read_address_1, 1'b1)));
      checkOutput("B.read_data_2", 32'(busB.read_data_2), 32'(expRead(busB.read_address_2, 1'b1)));
      checkOutput("N.read_data_1", 32'(busN.read_data_1), 32'(expRead(busB.read_address_1, 1'b0)));
      checkOutput("N.read_data_2", 32'(busN.read_data_2), 32'(expRead(busB.read_address_2, 1'b0)));
      checkOutput("B.busy_1", 32'(busB.busy_1), 32'(modelBusy[busB.read_address_1]));
      checkOutput("B.busy_2", 32'(busB.busy_2), 32'(modelBusy[busB.read_address_2]));
      checkOutput("N.busy_1", 32'(busN.busy_1), 32'(modelBusy[busB.read_address_1]));
      checkOutput("B.clear_active", 32'(busB.clear_active), 32'(modelSweeping));
      checkOutput("N.clear_active", 32'(busN.clear_active), 32'(modelSweeping));
    end
  end

  task automatic applyStimulus(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                               input bit ie, input logic [3:0] ia, input bit cr,
                               input logic [3:0] ra1, input logic [3:0] ra2);
    busB.write_enable   = we;
    busB.write_address  = wa;
    busB.write_data     = wd;
    busB.issue_enable   = ie;
    busB.issue_address  = ia;
    busB.clear_request  = cr;
    busB.read_address_1 = ra1;
    busB.read_address_2 = ra2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sweepCycles;

  initial begin
    checks   = 0;
    failures = 0;
    checkEn  = 1'b0;
    reset_n  = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    checkEn = 1'b1;

    // Reset state on every address of both ports.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 4'(a), 4'(15 - a));
      @(negedge clk);
      checkOutput("reset_rd1", 32'(busB.read_data_1), 32'h0);
      checkOutput("reset_rd2", 32'(busB.read_data_2), 32'h0);
      checkOutput("reset_busy", 32'({busB.busy_1, busB.busy_2}), 32'h0);
      tick();
    end

    // Forwarding of a same-cycle write, and its absence without bypass.
    applyStimulus(1, 3, 16'h1234, 0, 0, 0, 3, 0);
    @(negedge clk);
    checkOutput("bypass_rd1", 32'(busB.read_data_1), 32'h1234);
    checkOutput("nobypass_rd1", 32'(busN.read_data_1), 32'h0000);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    checkOutput("after_write_B", 32'(busB.read_data_1), 32'h1234);
    checkOutput("after_write_N", 32'(busN.read_data_1), 32'h1234);
    checkOutput("model_r3", 32'(modelMem[3]), 32'h1234);
    tick();

    // Busy scoreboard: issue, writeback, then issue and write together.
    applyStimulus(0, 0, 0, 1, 5, 0, 5, 5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
    @(negedge clk);
    checkOutput("issue_busy", 32'(busB.busy_1), 32'h1);
    tick();
    applyStimulus(1, 5, 16'hBEEF, 0, 0, 0, 5, 5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
    @(negedge clk);
    checkOutput("wb_busy", 32'(busB.busy_2), 32'h0);
    checkOutput("wb_data", 32'(busB.read_data_2), 32'hBEEF);
    tick();
    applyStimulus(1, 5, 16'hCAFE, 1, 5, 0, 5, 5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
    @(negedge clk);
    checkOutput("issue_wins_busy", 32'(busB.busy_1), 32'h1);
    checkOutput("issue_wins_data", 32'(busB.read_data_1), 32'hCAFE);
    checkOutput("model_busy5", 32'(modelBusy[5]), 32'h1);
    tick();

    // Fill every register (and claim it), then sweep.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1, 4'(a), 16'((a + 1) * 16'h0101), a[0], 4'(a), 0, 4'(a), 4'(a));
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    sweepCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) applyStimulus(1, 2, 16'hFFFF, 1, 2, 1, 2, 4'(i % 16));
      else        applyStimulus(0, 0, 0, 0, 0, 0, 4'(i % 16), 2);
      @(negedge clk);
      if (busB.clear_active) sweepCycles++;
      tick();
    end
    checkOutput("sweep_length", 32'(sweepCycles), 32'd16);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 4'(a), 4'(a));
      @(negedge clk);
      checkOutput("swept_data", 32'(busB.read_data_1), 32'h0);
      checkOutput("swept_busy", 32'(busB.busy_1), 32'h0);
      tick();
    end

    // Asynchronous reset in the middle of a sweep.
    applyStimulus(1, 15, 16'h5555, 0, 0, 0, 15, 15);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 15, 15);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 15, 15);
    tick();
    tick();
    @(negedge clk);
    checkOutput("midsweep_rd", 32'(busB.read_data_1), 32'h5555);
    checkOutput("midsweep_active", 32'(busB.clear_active), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_active", 32'(busB.clear_active), 32'h0);
    checkOutput("async_rst_rd", 32'(busB.read_data_1), 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    applyStimulus(1, 1, 16'h1111, 0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 15);
    @(negedge clk);
    checkOutput("post_rst_write", 32'(busB.read_data_1), 32'h1111);
    checkOutput("post_rst_r15", 32'(busB.read_data_2), 32'h0);
    tick();

    // Two ports on same and different addresses while writing a third.
    applyStimulus(1, 4, 16'h4444, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 6, 16'h6666, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 7, 16'h7777, 0, 0, 0, 4, 6);
    @(negedge clk);
    checkOutput("dual_diff_rd1", 32'(busB.read_data_1), 32'h4444);
    checkOutput("dual_diff_rd2", 32'(busB.read_data_2), 32'h6666);
    applyStimulus(1, 7, 16'h7777, 0, 0, 0, 4, 4);
    #1;
    checkOutput("dual_same_rd1", 32'(busB.read_data_1), 32'h4444);
    checkOutput("dual_same_rd2", 32'(busB.read_data_2), 32'h4444);
    applyStimulus(1, 7, 16'h7777, 0, 0, 0, 7, 4);
    #1;
    checkOutput("dual_byp_B", 32'(busB.read_data_1), 32'h7777);
    checkOutput("dual_byp_N", 32'(busN.read_data_1), 32'h0000);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 2) == 0, 4'($urandom), 16'($urandom),
                    ($urandom % 3) == 0, 4'($urandom), ($urandom % 50) == 0,
                    4'($urandom), 4'($urandom));
      tick();
    end

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
